// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry front end for a 4-bit ALU: sync + debounce of raw inputs, entry FSM, result latch.
// Latency: EXEC one cycle after the op-accepting press pulse; res_out/flags_out valid one cycle after op_valid.
// Backpressure: none; button presses are the only flow control and presses during EXEC are ignored.

// Debouncer for one raw button.
// Latency: 2 sync flops plus DEBOUNCE_CYCLES stable cycles before press_o.
// Backpressure: none; press_o is a single-cycle pulse on an accepted 0->1 change.
module alu_seq_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q, sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Count how long the synchronized level has disagreed with the accepted level.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q;
                cnt_d    = '0;
                press_d  = sync_q;    // only a rising accepted level is a press
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Two-flop synchronizer plus debounce state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            meta_q   <= btn_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;
endmodule

module alu_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int OPW             = 3,
    parameter int MAX_OP          = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [OPW-1:0]   op_out,
    output logic             op_valid,
    input  logic [WIDTH-1:0] res_in,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] res_out,
    output logic [3:0]       flags_out,
    output logic [1:0]       stage,
    output logic             op_err
);
    localparam logic [OPW-1:0] MAX_OP_L = OPW'(MAX_OP);

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             enter_press, clear_press;
    logic             op_legal;

    alu_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_enter),
        .press_o (enter_press)
    );

    alu_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_clear),
        .press_o (clear_press)
    );

    assign op_legal = (sw_sync_q[OPW-1:0] <= MAX_OP_L);

    // Entry FSM next state and operand/result register updates; clear overrides everything.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = 1'b0;
        if (clear_press) begin
            state_d = S_LOAD_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            flags_d = '0;
        end else begin
            case (state_q)
                S_LOAD_A: if (enter_press) begin
                    a_d     = sw_sync_q;
                    state_d = S_LOAD_B;
                end
                S_LOAD_B: if (enter_press) begin
                    b_d     = sw_sync_q;
                    state_d = S_LOAD_OP;
                end
                S_LOAD_OP: if (enter_press) begin
                    if (op_legal) begin
                        op_d    = sw_sync_q[OPW-1:0];
                        state_d = S_EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_EXEC: begin
                    // ALU output is combinational from the held operands; capture it now.
                    res_d   = res_in;
                    flags_d = flags_in;
                    state_d = S_SHOW;
                end
                S_SHOW: if (enter_press) begin
                    state_d = S_LOAD_A;
                end
                default: state_d = S_LOAD_A;
            endcase
        end
    end

    // State, switch synchronizer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LOAD_A;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            err_q     <= err_d;
        end
    end

    // LED stage code; EXEC shows as LOAD_OP since it lasts a single cycle.
    always_comb begin
        stage = 2'b00;
        case (state_q)
            S_LOAD_A:  stage = 2'b00;
            S_LOAD_B:  stage = 2'b01;
            S_LOAD_OP: stage = 2'b10;
            S_EXEC:    stage = 2'b10;
            S_SHOW:    stage = 2'b11;
            default:   stage = 2'b00;
        endcase
    end

    assign op_valid  = (state_q == S_EXEC) && !clear_press;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign op_out    = op_q;
    assign res_out   = res_q;
    assign flags_out = flags_q;
    assign op_err    = err_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a short debounce window.
// Latency: each button press is held and released long enough to pass the debouncer.
// Backpressure: n/a; a scoreboard queue holds expected EXEC transactions for the monitor.
module tb_alu_operand_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = '0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] a_out, b_out, res_out, flags_out;
    logic [2:0] op_out;
    logic       op_valid, op_err;
    logic [3:0] res_in = '0;
    logic [3:0] flags_in = '0;
    logic [1:0] stage;

    alu_operand_sequencer #(
        .WIDTH(4), .OPW(3), .MAX_OP(6), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_out    (op_out),
        .op_valid  (op_valid),
        .res_in    (res_in),
        .flags_in  (flags_in),
        .res_out   (res_out),
        .flags_out (flags_out),
        .stage     (stage),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic [3:0] flags;
        bit         chk_res;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   err_cnt = 0;
    bit   pending = 1'b0;
    bit   prev_v = 1'b0;
    int   e0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                                input logic [3:0] res, input logic [3:0] flags, input bit chk_res);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.res = res; e.flags = flags; e.chk_res = chk_res;
        return e;
    endfunction

    // Drive buttons for long enough to be accepted, then release and let them settle.
    task automatic press(input logic en, input logic cl, input logic [3:0] v);
        sw        = v;
        btn_enter = en;
        btn_clear = cl;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Press enter with an opcode and hit reset while op_valid is high.
    task automatic exec_abort(input logic [3:0] v);
        bit got = 1'b0;
        sw        = v;
        btn_enter = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = op_valid;
        end
        chk("t5_exec_seen", {31'd0, got}, 32'd1);
        #1 rst = 1'b1;
        btn_enter = 1'b0;
        #1;
        chk("t5_async_a", a_out, 0);
        chk("t5_async_b", b_out, 0);
        chk("t5_async_op", op_out, 0);
        chk("t5_async_valid", op_valid, 0);
        chk("t5_async_res", res_out, 0);
        chk("t5_async_flags", flags_out, 0);
        chk("t5_async_stage", stage, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_after_stage", stage, 0);
        chk("t5_after_valid", op_valid, 0);
    endtask

    // Monitor: pops the scoreboard on each op_valid and checks the latched result a cycle later.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (cur.chk_res) begin
                    chk("sb_valid_fall", op_valid, 0);
                    chk("sb_res", res_out, cur.res);
                    chk("sb_flags", flags_out, cur.flags);
                    chk("sb_stage_show", stage, 2'b11);
                end
            end
            if (op_err) err_cnt++;
            if (op_valid) begin
                chk("sb_valid_width", {31'd0, prev_v}, 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_valid: got op_valid=1 required no transaction");
                end else begin
                    cur = sb_q.pop_front();
                    chk("sb_a", a_out, cur.a);
                    chk("sb_b", b_out, cur.b);
                    chk("sb_op", op_out, cur.op);
                    chk("sb_stage_exec", stage, 2'b10);
                    pending = 1'b1;
                end
            end
            prev_v = op_valid;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_op", op_out, 0);
        chk("rst_valid", op_valid, 0);
        chk("rst_res", res_out, 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_stage", stage, 0);
        chk("rst_err", op_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic entry 3, 5, add
        res_in = 4'h8; flags_in = 4'b0000;
        press(1, 0, 4'h3);
        chk("t1_stage_b", stage, 2'b01);
        chk("t1_a", a_out, 4'h3);
        press(1, 0, 4'h5);
        chk("t1_stage_op", stage, 2'b10);
        chk("t1_b", b_out, 4'h5);
        sb_q.push_back(mk(4'h3, 4'h5, 3'd0, 4'h8, 4'h0, 1));
        press(1, 0, 4'h0);
        chk("t1_stage_show", stage, 2'b11);
        chk("t1_res", res_out, 4'h8);

        // SHOW -> LOAD_A keeps result and operands
        press(1, 0, 4'hF);
        chk("show_exit_stage", stage, 2'b00);
        chk("show_exit_res", res_out, 4'h8);
        chk("show_exit_a", a_out, 4'h3);

        // 2: bouncing enter produces one press only
        sw = 4'hA;
        for (int i = 0; i < 10; i++) begin
            btn_enter = (i % 2 == 0);
            @(negedge clk);
        end
        chk("t2_bounce_stage", stage, 2'b00);
        btn_enter = 1'b1;
        repeat (6) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_one_press_stage", stage, 2'b01);
        chk("t2_a", a_out, 4'hA);

        // 3: illegal opcode rejected, then legal one accepted
        press(1, 0, 4'hB);
        chk("t3_stage_op", stage, 2'b10);
        e0 = err_cnt;
        press(1, 0, 4'h7);
        chk("t3_err_pulses", err_cnt - e0, 1);
        chk("t3_stage_stay", stage, 2'b10);
        chk("t3_op_unchanged", op_out, 3'd0);
        res_in = 4'h3; flags_in = 4'b0011;
        sb_q.push_back(mk(4'hA, 4'hB, 3'd4, 4'h3, 4'b0011, 1));
        press(1, 0, 4'h4);
        chk("t3_op", op_out, 3'd4);

        // 4: enter and clear together in LOAD_B -> clear wins
        press(1, 0, 4'h0);
        press(1, 0, 4'h9);
        chk("t4_stage_b", stage, 2'b01);
        chk("t4_a_pre", a_out, 4'h9);
        press(1, 1, 4'h6);
        chk("t4_stage", stage, 2'b00);
        chk("t4_a", a_out, 0);
        chk("t4_b", b_out, 0);
        chk("t4_op", op_out, 0);
        chk("t4_res", res_out, 0);
        chk("t4_flags", flags_out, 0);

        // 5: async reset during EXEC
        press(1, 0, 4'h2);
        press(1, 0, 4'h3);
        res_in = 4'h5; flags_in = 4'b0001;
        sb_q.push_back(mk(4'h2, 4'h3, 3'd1, 4'h5, 4'b0001, 0));
        exec_abort(4'h1);

        // 6: result retained through SHOW exit, then overwritten by next entry
        res_in = 4'hC; flags_in = 4'b1010;
        press(1, 0, 4'h2);
        press(1, 0, 4'h6);
        sb_q.push_back(mk(4'h2, 4'h6, 3'd5, 4'hC, 4'b1010, 1));
        press(1, 0, 4'h5);
        chk("t6_stage_show", stage, 2'b11);
        press(1, 0, 4'h0);
        chk("t6_stage_a", stage, 2'b00);
        chk("t6_res_kept", res_out, 4'hC);
        chk("t6_flags_kept", flags_out, 4'b1010);
        press(1, 0, 4'h1);
        chk("t6_a_new", a_out, 4'h1);
        chk("t6_b_old", b_out, 4'h6);
        chk("t6_op_old", op_out, 3'd5);
        press(1, 0, 4'h1);
        res_in = 4'h0; flags_in = 4'b0100;
        sb_q.push_back(mk(4'h1, 4'h1, 3'd1, 4'h0, 4'b0100, 1));
        press(1, 0, 4'h1);
        chk("t6_res_new", res_out, 4'h0);
        chk("t6_flags_new", flags_out, 4'b0100);

        repeat (3) @(negedge clk);
        chk("end_sb_empty", sb_q.size(), 0);
        chk("end_err_total", err_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
